// File: rtl/alu_queue_unit.sv
// -----------------------------------------------------------------------------
// alu_queue_unit
//
// Integer ALU execute stage followed by a DEPTH-entry in-order result queue.
// The ALU result is computed combinationally in the issue cycle and written
// into the queue on push. The queue head drains to commit through a
// valid/ready handshake and is mirrored onto the bypass network.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   flush                  synchronous flush, empties the queue at next edge
//   in_valid / in_ready    issue handshake (in_ready depends on count only)
//   in_op                  5-bit operation code
//   in_src1, in_src2       register operands
//   in_imm                 16-bit immediate
//   in_src1_is_sa          src1 := zero-extended in_imm[10:6]
//   in_src2_is_simm        src2 := sign-extended in_imm (wins over zimm)
//   in_src2_is_zimm        src2 := zero-extended in_imm
//   in_rf_we, in_dest      register write enable / physical destination
//   in_tag                 ROB entry number
//   out_valid / out_ready  commit handshake for the head entry
//   out_tag, out_dest, out_rf_we, out_result, out_ex, out_exccode
//                          head entry fields (zero while queue is empty)
//   byp_valid, byp_dest, byp_result
//                          bypass copy of the head (valid only if it writes)
//   count                  current occupancy
// -----------------------------------------------------------------------------
module alu_queue_unit #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 4,
    parameter int PREG_W = 6,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [31:0]       in_src1,
    input  logic [31:0]       in_src2,
    input  logic [15:0]       in_imm,
    input  logic              in_src1_is_sa,
    input  logic              in_src2_is_simm,
    input  logic              in_src2_is_zimm,
    input  logic              in_rf_we,
    input  logic [PREG_W-1:0] in_dest,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [PREG_W-1:0] out_dest,
    output logic              out_rf_we,
    output logic [31:0]       out_result,
    output logic              out_ex,
    output logic [4:0]        out_exccode,
    output logic              byp_valid,
    output logic [PREG_W-1:0] byp_dest,
    output logic [31:0]       byp_result,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBU = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOR  = 5'd9;
    localparam logic [4:0] OP_SLL  = 5'd10;
    localparam logic [4:0] OP_SRL  = 5'd11;
    localparam logic [4:0] OP_SRA  = 5'd12;
    localparam logic [4:0] OP_LUI  = 5'd13;
    localparam logic [4:0] OP_CLZ  = 5'd14;
    localparam logic [4:0] OP_CLO  = 5'd15;
    localparam logic [4:0] OP_PASS = 5'd16;

    localparam logic [4:0] EXC_OV  = 5'h0C;

    // Leading-zero count over 32 bits; result range 0..32.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        logic       hit;
        n   = 6'd0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (hit || v[i]) begin
                hit = 1'b1;
            end else begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

    // Pointer increment with wrap at DEPTH-1 (handles non-power-of-2 depths).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] q;
        if (p == PTR_W'(DEPTH - 1)) begin
            q = {PTR_W{1'b0}};
        end else begin
            q = p + PTR_W'(1);
        end
        return q;
    endfunction

    // ---------------------------------------------------------------- state
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic [TAG_W-1:0]  tag_mem_r    [DEPTH];
    logic [PREG_W-1:0] dest_mem_r   [DEPTH];
    logic              rfwe_mem_r   [DEPTH];
    logic [31:0]       result_mem_r [DEPTH];
    logic              ex_mem_r     [DEPTH];
    logic [4:0]        exc_mem_r    [DEPTH];

    // ------------------------------------------------------------ ALU nets
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    logic [32:0] add33_s;
    logic [32:0] sub33_s;
    logic [31:0] result_s;
    logic        ovf_s;
    logic        push_s;
    logic        pop_s;
    logic        in_ready_s;
    logic        out_valid_s;

    assign in_ready_s  = (count_r < CNT_W'(DEPTH));
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = in_valid & in_ready_s;
    assign pop_s       = out_valid_s & out_ready;

    // Operand selection: shift amount from the immediate, simm over zimm.
    always_comb begin
        src1_s = in_src1;
        src2_s = in_src2;
        if (in_src1_is_sa) begin
            src1_s = {27'd0, in_imm[10:6]};
        end else begin
            src1_s = in_src1;
        end
        if (in_src2_is_simm) begin
            src2_s = {{16{in_imm[15]}}, in_imm};
        end else if (in_src2_is_zimm) begin
            src2_s = {16'd0, in_imm};
        end else begin
            src2_s = in_src2;
        end
    end

    // 33-bit sign-extended arithmetic so signed overflow is bit32 != bit31.
    assign add33_s = {src1_s[31], src1_s} + {src2_s[31], src2_s};
    assign sub33_s = {src1_s[31], src1_s} - {src2_s[31], src2_s};

    // ALU result and overflow detection; only ADD and SUB can trap.
    always_comb begin
        result_s = 32'd0;
        ovf_s    = 1'b0;
        case (in_op)
            OP_ADD: begin
                result_s = add33_s[31:0];
                ovf_s    = add33_s[32] ^ add33_s[31];
            end
            OP_ADDU: result_s = add33_s[31:0];
            OP_SUB: begin
                result_s = sub33_s[31:0];
                ovf_s    = sub33_s[32] ^ sub33_s[31];
            end
            OP_SUBU: result_s = sub33_s[31:0];
            OP_SLT:  result_s = {31'd0, ($signed(src1_s) < $signed(src2_s))};
            OP_SLTU: result_s = {31'd0, (src1_s < src2_s)};
            OP_AND:  result_s = src1_s & src2_s;
            OP_OR:   result_s = src1_s | src2_s;
            OP_XOR:  result_s = src1_s ^ src2_s;
            OP_NOR:  result_s = ~(src1_s | src2_s);
            OP_SLL:  result_s = src2_s << src1_s[4:0];
            OP_SRL:  result_s = src2_s >> src1_s[4:0];
            OP_SRA:  result_s = $unsigned($signed(src2_s) >>> src1_s[4:0]);
            OP_LUI:  result_s = {in_imm, 16'd0};
            // Count operations look at the raw register value, not src1_s.
            OP_CLZ:  result_s = {26'd0, clz32(in_src1)};
            OP_CLO:  result_s = {26'd0, clz32(~in_src1)};
            OP_PASS: result_s = in_src1;
            default: begin
                result_s = 32'd0;
                ovf_s    = 1'b0;
            end
        endcase
    end

    // Entry storage: written only on an accepted, non-flushed push; not reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            tag_mem_r[wr_ptr_r]    <= in_tag;
            dest_mem_r[wr_ptr_r]   <= in_dest;
            rfwe_mem_r[wr_ptr_r]   <= in_rf_we & ~ovf_s;
            result_mem_r[wr_ptr_r] <= result_s;
            ex_mem_r[wr_ptr_r]     <= ovf_s;
            exc_mem_r[wr_ptr_r]    <= ovf_s ? EXC_OV : 5'd0;
        end
    end

    // Queue pointers and occupancy; flush overrides any push/pop that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head outputs; forced to zero while empty so storage contents never leak.
    always_comb begin
        in_ready    = in_ready_s;
        out_valid   = out_valid_s;
        count       = count_r;
        out_tag     = {TAG_W{1'b0}};
        out_dest    = {PREG_W{1'b0}};
        out_rf_we   = 1'b0;
        out_result  = 32'd0;
        out_ex      = 1'b0;
        out_exccode = 5'd0;
        if (out_valid_s) begin
            out_tag     = tag_mem_r[rd_ptr_r];
            out_dest    = dest_mem_r[rd_ptr_r];
            out_rf_we   = rfwe_mem_r[rd_ptr_r];
            out_result  = result_mem_r[rd_ptr_r];
            out_ex      = ex_mem_r[rd_ptr_r];
            out_exccode = exc_mem_r[rd_ptr_r];
        end else begin
            out_tag     = {TAG_W{1'b0}};
        end
        byp_valid  = out_valid_s & out_rf_we;
        byp_dest   = out_dest;
        byp_result = out_result;
    end

endmodule

// File: doc/alu_queue_unit.md
Name: alu_queue_unit

Overview:
Parametrised successor of the single-issue integer ALU execute unit.
- Computes the ALU result in the issue cycle and writes the finished result into a DEPTH-entry in-order result queue.
- The queue drains to the commit stage through a valid/ready handshake.
- Queue depth, ROB tag width and physical-register width are parameters.
- New over the previous unit: occupancy output, overflow suppresses register write and bypass, and non-power-of-2 depths are supported.

Parameters:
DEPTH, 2, result-queue entries; legal range is 1 or more, non-power-of-2 allowed.
TAG_W, 4, ROB entry-number width.
PREG_W, 6, physical destination register address width.
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  issue presents an instruction
in_ready  out  1  queue accepts this cycle
in_op  in  5  operation code (see Behaviour)
in_src1  in  32  source 1 value
in_src2  in  32  source 2 value
in_imm  in  16  immediate field
in_src1_is_sa  in  1  src1 = zero-extended in_imm[10:6]
in_src2_is_simm  in  1  src2 = sign-extended in_imm
in_src2_is_zimm  in  1  src2 = zero-extended in_imm
in_rf_we  in  1  instruction writes the register file
in_dest  in  PREG_W  physical destination
in_tag  in  TAG_W  ROB entry number
out_valid  out  1  head entry valid
out_ready  in  1  commit accepts head
out_tag  out  TAG_W  head ROB entry
out_dest  out  PREG_W  head destination
out_rf_we  out  1  head register write enable
out_result  out  32  head result
out_ex  out  1  head raises an exception
out_exccode  out  5  head exception code
byp_valid  out  1  out_valid and out_rf_we
byp_dest  out  PREG_W  equals out_dest
byp_result  out  32  equals out_result
count  out  CNT_W  current occupancy

Behaviour:
Reset (resetn low, asynchronous):
- Pointers and count go to 0.
- Every output is 0 except in_ready, which is 1.
- Reset asserted mid-operation discards all entries immediately.
- Entry storage is not reset.

Handshake:
- in_ready = (count < DEPTH); it is combinational from count only and never depends on out_ready.
- Push = in_valid and in_ready. Pop = out_valid and out_ready.
- out_valid = (count != 0). All out_* and byp_* outputs are driven from the head entry.

Timing:
- Minimum latency from push to visibility at out_valid is 1 cycle.
- A simultaneous push and pop at 0 < count < DEPTH leaves count unchanged and preserves order.
- When full, push is blocked even if a pop occurs in the same cycle.

Pointers:
- Width is max(1, $clog2(DEPTH)).
- Each pointer wraps from DEPTH-1 to 0.

Flush:
- At the next edge, pointers and count go to 0.
- A push or pop in the flush cycle is discarded; flush has priority.

Operand selection:
- src1 = in_src1_is_sa ? {27'b0, in_imm[10:6]} : in_src1.
- src2 = simm ? sign-extended in_imm : zimm ? zero-extended in_imm : in_src2. simm has priority over zimm.

Opcodes:
- 0 ADD, 1 ADDU, 2 SUB, 3 SUBU: 32-bit add/subtract, wraparound.
- 4 SLT: signed compare, result 1 or 0.
- 5 SLTU: unsigned compare.
- 6 AND, 7 OR, 8 XOR, 9 NOR.
- 10 SLL: src2 << src1[4:0].
- 11 SRL: logical right shift of src2 by src1[4:0].
- 12 SRA: arithmetic right shift of src2 by src1[4:0].
- 13 LUI: {in_imm, 16'b0}.
- 14 CLZ: leading zeros of in_src1 (raw value, not the operand-select output), range 0..32.
- 15 CLO: leading ones of in_src1 (raw value), range 0..32.
- 16 PASS: result = in_src1 (used for MFHI/MFLO/MTHI/MTLO).
- 17..31: result 0, no exception.

Overflow:
- Applies to ADD and SUB only: signed overflow of a 33-bit sign-extended add.
- On overflow the entry stores ex=1, exccode=5'h0C and rf_we=0. The result field still holds the wrapped sum.
- For all other cases ex=0 and exccode=0.

Stored entry fields:
- tag, dest, rf_we (already masked by overflow), result, ex, exccode.
- Fields are written only on push and are never modified while queued.

Test Plan:
- Reset: hold resetn=0, then release -> in_ready=1, out_valid=0, count=0, byp_valid=0. Push one entry, assert resetn=0 asynchronously mid-cycle -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
- Arithmetic: ADD 0x7FFFFFFF+1 -> out_result=0x80000000, out_ex=1, out_exccode=0x0C, out_rf_we=0, byp_valid=0. ADDU with the same operands -> ex=0, rf_we=1.
- Compares and shifts:
  - SLT src1=0xFFFFFFFF, src2=1 -> 1; SLTU with the same operands -> 0.
  - SRA src2=0x80000000, sa via imm[10:6]=4 -> 0xF8000000; SRL with the same operands -> 0x08000000.
  - LUI imm=0x1234 -> 0x12340000.
  - CLZ 0x00010000 -> 15; CLO 0xFFFFFFFF -> 32.
- Backpressure, DEPTH=2, out_ready=0:
  - Push tags 1 and 2 -> count=2, in_ready=0.
  - Push tag 3 held with out_ready=1 in the same cycle -> tag 1 pops and tag 3 is not accepted; next cycle tag 3 is accepted.
  - Drain order is 1, 2, 3.
- Steady stream, DEPTH=3, in_valid=1 and out_ready=1 continuously -> count stays 1, one result per cycle, pointers wrap correctly past entry 2.
- Flush: count=2, then assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0; the entry presented in the flush cycle never appears on the output.
